serial_bit_feeder: RTL and testbench

//  Parallel-to-serial front end for the bit-serial sequence-detector chain.

---
 rtl/serial_feeder_pkg.sv | 19 +
 rtl/feeder_bit_counter.sv | 32 +++
 rtl/serial_bit_feeder.sv | 149 ++++++++++++++
 tb/tb_serial_bit_feeder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial bit feeder and the downstream detector bench.
// State encodings, the idle line level and the word-parity helper live here.
package serial_feeder_pkg;

  typedef logic [1:0] feeder_state_t;

  localparam feeder_state_t ST_IDLE   = 2'd0;
  localparam feeder_state_t ST_SHIFT  = 2'd1;
  localparam feeder_state_t ST_PARITY = 2'd2;

  localparam logic IDLE_BIT_DEFAULT = 1'b1;
  localparam int   MAX_WIDTH        = 32;

  // Even parity over a word zero-extended to MAX_WIDTH bits.
  function automatic logic word_parity(input logic [MAX_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/feeder_bit_counter.sv
// Loadable down-counter with an is-zero flag; counts only on enabled ticks
// and parks at zero, so the owning FSM must reload it for the next word.
module feeder_bit_counter #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  input  logic          i_tick,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Load has priority over counting; a load and a last-bit tick may coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && i_tick && (r_cnt != {CW{1'b0}})) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: words accepted on valid/ready, sent MSB-first one bit per tick.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit to every word.
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             tick,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  feeder_state_t    r_state;
  feeder_state_t    w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_x;
  logic             r_x_valid;
  logic             r_done;
  logic             w_cnt_zero;
  logic             w_frame_end;
  logic             w_accept;
  logic             w_shift_tick;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             r_par;
`endif

`ifdef SERIAL_FEEDER_PARITY_EN
  assign w_frame_end = (r_state == ST_PARITY) && tick;
`else
  assign w_frame_end = (r_state == ST_SHIFT) && tick && w_cnt_zero;
`endif

  // A new word may only enter from idle or on the tick that finishes the current frame.
  assign in_ready     = (r_state == ST_IDLE) || w_frame_end;
  assign w_accept     = in_valid && in_ready;
  assign w_shift_tick = (r_state == ST_SHIFT) && tick;

  feeder_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val (LAST_IDX),
    .i_en       (r_state == ST_SHIFT),
    .i_tick     (tick),
    .o_zero     (w_cnt_zero)
  );

  // Next-state decode for the IDLE/SHIFT(/PARITY) frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (tick && w_cnt_zero) begin
`ifdef SERIAL_FEEDER_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          if (w_accept) begin
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (w_accept) begin
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output registers; a reload in the frame-end cycle overrides the shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sreg    <= {WIDTH{1'b0}};
      r_x       <= IDLE_BIT;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
      if (w_shift_tick) begin
        r_x       <= r_sreg[WIDTH-1];
        r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
        r_x_valid <= 1'b1;
`ifndef SERIAL_FEEDER_PARITY_EN
        r_done    <= w_cnt_zero;
`endif
`ifdef SERIAL_FEEDER_PARITY_EN
      end else if ((r_state == ST_PARITY) && tick) begin
        r_x       <= r_par;
        r_x_valid <= 1'b1;
        r_done    <= 1'b1;
`endif
      end else if ((r_state == ST_IDLE) && tick) begin
        r_x <= IDLE_BIT;
      end
      if (w_accept) begin
        r_sreg <= in_data;
`ifdef SERIAL_FEEDER_PARITY_EN
        r_par  <= word_parity(MAX_WIDTH'(in_data));
`endif
      end
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder (WIDTH=8, IDLE_BIT=1); the parity build
// (SERIAL_FEEDER_PARITY_EN) runs the reset check plus the parity-frame sequence.
module tb_serial_bit_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tick;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;

  serial_bit_feeder #(
    .WIDTH    (8),
    .IDLE_BIT (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tick     (tick),
    .x        (x),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".x"}, x, 1'b1);
    chk({tag, ".x_valid"}, x_valid, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".in_ready"}, in_ready, 1'b1);
  endtask

  // One word with tick held high; exp holds the hand-written MSB-first bit pattern.
  // reload=1 means another word is accepted on the last bit (back-to-back).
  task automatic send_word(input string tag, input logic [7:0] exp, input logic reload);
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk); #1;
      chk($sformatf("%s.x[%0d]", tag, i), x, exp[i]);
      chk($sformatf("%s.xv[%0d]", tag, i), x_valid, 1'b1);
      chk($sformatf("%s.done[%0d]", tag, i), done, (i == 0));
      chk($sformatf("%s.rdy[%0d]", tag, i), in_ready, (i == 1) || ((i == 0) && !reload));
      chk($sformatf("%s.busy[%0d]", tag, i), busy, (i != 0) || reload);
    end
  endtask

  initial begin
    logic       prev_x;
    logic [7:0] exp_bits;
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    tick     = 1'b0;

    // 1: reset values, then release
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("rst_hold");
    reset = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("rst_rel");

`ifndef SERIAL_FEEDER_PARITY_EN
    // 2: single word 8'h66 with tick held high
    tick     = 1'b1;
    in_data  = 8'h66;
    in_valid = 1'b1;
    chk("w66.rdy_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("w66.busy_after_accept", busy, 1'b1);
    chk("w66.xv_after_accept", x_valid, 1'b0);
    chk("w66.rdy_after_accept", in_ready, 1'b0);
    send_word("w66", 8'b0110_0110, 1'b0);
    @(posedge clk); #1;
    chk("idle_tick.x", x, 1'b1);
    chk("idle_tick.xv", x_valid, 1'b0);
    chk("idle_tick.busy", busy, 1'b0);

    // 3: 8'hA5 then 8'h3C back-to-back, in_valid held through the first word
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data  = 8'h3C;
    send_word("wA5", 8'b1010_0101, 1'b1);
    in_valid = 1'b0;
    send_word("w3C", 8'b0011_1100, 1'b0);

    // 4: tick every 4th clock, 8'h81
    @(posedge clk); #1;
    chk("t4.idle_x", x, 1'b1);
    tick     = 1'b0;
    in_data  = 8'h81;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4.busy_accept", busy, 1'b1);
    chk("t4.x_hold_accept", x, 1'b1);
    exp_bits = 8'b1000_0001;
    prev_x   = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk($sformatf("t4.hold_x[%0d.%0d]", i, k), x, prev_x);
        chk($sformatf("t4.hold_xv[%0d.%0d]", i, k), x_valid, 1'b0);
        chk($sformatf("t4.hold_busy[%0d.%0d]", i, k), busy, 1'b1);
      end
      tick = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("t4.x[%0d]", i), x, exp_bits[i]);
      chk($sformatf("t4.xv[%0d]", i), x_valid, 1'b1);
      chk($sformatf("t4.done[%0d]", i), done, (i == 0));
      prev_x = exp_bits[i];
    end
    chk("t4.busy_end", busy, 1'b0);

    // 5: 8'hF0 aborted by asynchronous reset after 3 bits, then 8'h0F clean
    tick     = 1'b1;
    in_data  = 8'hF0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5.pre_x[%0d]", i), x, 1'b1);
      chk($sformatf("t5.pre_xv[%0d]", i), x_valid, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    chk_idle_outputs("t5.async_rst");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5.rdy_after_rel", in_ready, 1'b1);
    in_data  = 8'h0F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_word("w0F", 8'b0000_1111, 1'b0);
`else
    // 6: parity build, 8'h07 -> 0000_0111 then even-parity bit 1
    tick     = 1'b1;
    in_data  = 8'h07;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_bits = 8'b0000_0111;
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk); #1;
      chk($sformatf("par.x[%0d]", i), x, exp_bits[i]);
      chk($sformatf("par.xv[%0d]", i), x_valid, 1'b1);
      chk($sformatf("par.done[%0d]", i), done, 1'b0);
      chk($sformatf("par.rdy[%0d]", i), in_ready, (i == 0));
    end
    @(posedge clk); #1;
    chk("par.pbit_x", x, 1'b1);
    chk("par.pbit_xv", x_valid, 1'b1);
    chk("par.pbit_done", done, 1'b1);
    chk("par.pbit_busy", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
